// File: rtl/vedic_pkg.sv
// Shared constants, state encoding and parameter legality check for the
// iterative Vedic multiplier.
package vedic_pkg;

   localparam int DIGIT_W   = 16;
   localparam int DIGIT_LOG = $clog2(DIGIT_W);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } state_e;

   function automatic bit width_ok(input int w);
      return (w >= 16) && (w <= 128) && ((w % DIGIT_W) == 0);
   endfunction

endpackage

// File: rtl/vedic_pp16.sv
// Combinational 16x16 -> 32 Vedic (Urdhva-Tiryagbhyam) multiplier, composed
// 2x2 -> 4x4 -> 8x8 -> 16x16 from vertical and crosswise partial products.
module vedic_pp16 (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   output logic [31:0] p_o
);

   function automatic logic [3:0] mul2(input logic [1:0] x, input logic [1:0] y);
      logic c;
      c = x[1] & y[0] & x[0] & y[1];
      return {x[1] & y[1] & c, (x[1] & y[1]) ^ c, (x[1] & y[0]) ^ (x[0] & y[1]), x[0] & y[0]};
   endfunction

   function automatic logic [7:0] mul4(input logic [3:0] x, input logic [3:0] y);
      logic [3:0] hh, hl, lh, ll;
      hh = mul2(x[3:2], y[3:2]);
      hl = mul2(x[3:2], y[1:0]);
      lh = mul2(x[1:0], y[3:2]);
      ll = mul2(x[1:0], y[1:0]);
      return {hh, 4'b0} + {2'b0, hl, 2'b0} + {2'b0, lh, 2'b0} + {4'b0, ll};
   endfunction

   function automatic logic [15:0] mul8(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] hh, hl, lh, ll;
      hh = mul4(x[7:4], y[7:4]);
      hl = mul4(x[7:4], y[3:0]);
      lh = mul4(x[3:0], y[7:4]);
      ll = mul4(x[3:0], y[3:0]);
      return {hh, 8'b0} + {4'b0, hl, 4'b0} + {4'b0, lh, 4'b0} + {8'b0, ll};
   endfunction

   logic [15:0] hh, hl, lh, ll;

   always_comb begin
      hh  = mul8(a_i[15:8], b_i[15:8]);
      hl  = mul8(a_i[15:8], b_i[7:0]);
      lh  = mul8(a_i[7:0],  b_i[15:8]);
      ll  = mul8(a_i[7:0],  b_i[7:0]);
      p_o = {hh, 16'b0} + {8'b0, hl, 8'b0} + {8'b0, lh, 8'b0} + {16'b0, ll};
   end

endmodule

// File: rtl/vedic_mult_iter.sv
// Iterative sign-magnitude multiplier: one 16x16 Vedic partial product per
// cycle accumulated into a 2*WIDTH register, sign applied once at the end.
module vedic_mult_iter
   import vedic_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int SIGNED_EN = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               is_signed,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] p,
   output logic               busy
);

   if (!width_ok(WIDTH)) begin : g_bad_width
      $error("vedic_mult_iter: WIDTH=%0d must be a multiple of 16 in 16..128", WIDTH);
   end

   localparam int K     = WIDTH / DIGIT_W;
   localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
   localparam int PW    = 2 * WIDTH;
   localparam int SH_W  = $clog2(PW);
   localparam int SUM_W = SH_W - DIGIT_LOG;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(K - 1);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_mag_q, a_mag_d, b_mag_q, b_mag_d;
   logic               neg_q, neg_d;
   logic [PW-1:0]      acc_q, acc_d, p_q, p_d;
   logic [IDX_W-1:0]   i_q, i_d, j_q, j_d;

   logic               sgn_mode, a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [DIGIT_W-1:0] pp_a, pp_b;
   logic [2*DIGIT_W-1:0] pp;
   logic [SH_W-1:0]    shamt;
   logic [PW-1:0]      pp_shift;

   // Magnitude of the most negative value wraps onto itself, which is the
   // correct unsigned magnitude 2^(WIDTH-1).
   assign sgn_mode = (SIGNED_EN != 0) && is_signed;
   assign a_neg    = sgn_mode & a[WIDTH-1];
   assign b_neg    = sgn_mode & b[WIDTH-1];
   assign a_mag    = a_neg ? -a : a;
   assign b_mag    = b_neg ? -b : b;

   assign pp_a     = a_mag_q[int'(i_q) * DIGIT_W +: DIGIT_W];
   assign pp_b     = b_mag_q[int'(j_q) * DIGIT_W +: DIGIT_W];
   assign shamt    = {SUM_W'(i_q) + SUM_W'(j_q), {DIGIT_LOG{1'b0}}};
   assign pp_shift = PW'(pp) << shamt;

   vedic_pp16 u_pp16 (
      .a_i (pp_a),
      .b_i (pp_b),
      .p_o (pp)
   );

   always_comb begin
      // NOTE: every *_d gets its hold value first so no path through the
      // case can leave a signal unassigned and infer a latch.
      state_d = state_q;
      a_mag_d = a_mag_q;
      b_mag_d = b_mag_q;
      neg_d   = neg_q;
      acc_d   = acc_q;
      i_d     = i_q;
      j_d     = j_q;
      p_d     = p_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_mag_d = a_mag;
               b_mag_d = b_mag;
               neg_d   = a_neg ^ b_neg;
               acc_d   = '0;
               i_d     = '0;
               j_d     = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            acc_d = acc_q + pp_shift;
            if (j_q == LAST) begin
               j_d = '0;
               if (i_q == LAST) state_d = FIX;
               else             i_d     = i_q + IDX_W'(1);
            end else begin
               j_d = j_q + IDX_W'(1);
            end
         end
         FIX: begin
            p_d     = neg_q ? -acc_q : acc_q;
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: non-blocking assignments keep every register sampling the
   // pre-edge value of its neighbours, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_mag_q <= '0;
         b_mag_q <= '0;
         neg_q   <= 1'b0;
         acc_q   <= '0;
         i_q     <= '0;
         j_q     <= '0;
         p_q     <= '0;
      end else begin
         a_mag_q <= a_mag_d;
         b_mag_q <= b_mag_d;
         neg_q   <= neg_d;
         acc_q   <= acc_d;
         i_q     <= i_d;
         j_q     <= j_d;
         p_q     <= p_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = (state_q == DONE);
   assign p         = p_q;

endmodule

// File: tb/tb_vedic_mult_iter.sv
// Self-checking bench for vedic_mult_iter: two WIDTH=32 instances (signed
// mode enabled / disabled) sharing stimulus, plus one WIDTH=64 instance.
module tb_vedic_mult_iter;

   logic        clk = 1'b0;
   logic        rst;

   logic        in_valid, is_signed, out_ready;
   logic [31:0] a, b;
   logic        in_ready_s, out_valid_s, busy_s;
   logic [63:0] p_s;
   logic        in_ready_u, out_valid_u, busy_u;
   logic [63:0] p_u;

   logic         in_valid64, is_signed64, out_ready64;
   logic [63:0]  a64, b64;
   logic         in_ready64, out_valid64, busy64;
   logic [127:0] p64;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   vedic_mult_iter #(.WIDTH(32), .SIGNED_EN(1)) dut_s (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
      .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid_s),
      .out_ready(out_ready), .p(p_s), .busy(busy_s)
   );

   vedic_mult_iter #(.WIDTH(32), .SIGNED_EN(0)) dut_u (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u),
      .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid_u),
      .out_ready(out_ready), .p(p_u), .busy(busy_u)
   );

   vedic_mult_iter #(.WIDTH(64), .SIGNED_EN(1)) dut_64 (
      .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(in_ready64),
      .a(a64), .b(b64), .is_signed(is_signed64), .out_valid(out_valid64),
      .out_ready(out_ready64), .p(p64), .busy(busy64)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: plain two's-complement product, truncated to 2*W bits.
   function automatic logic [63:0] model32(input logic [31:0] x, input logic [31:0] y, input bit s);
      logic signed [63:0] sx, sy;
      sx = s ? {{32{x[31]}}, x} : {32'b0, x};
      sy = s ? {{32{y[31]}}, y} : {32'b0, y};
      return sx * sy;
   endfunction

   function automatic logic [127:0] model64(input logic [63:0] x, input logic [63:0] y, input bit s);
      logic signed [127:0] sx, sy;
      sx = s ? {{64{x[63]}}, x} : {64'b0, x};
      sy = s ? {{64{y[63]}}, y} : {64'b0, y};
      return sx * sy;
   endfunction

   function automatic logic [31:0] pick32();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h1;
         default: return $urandom;
      endcase
   endfunction

   // One transaction on the two WIDTH=32 instances; exp_s/exp_u are the
   // required products for the signed-enabled and signed-disabled copies.
   task automatic run32(input logic [31:0] av, input logic [31:0] bv, input bit s,
                        input int hold, input bit poke,
                        input logic [63:0] exp_s, input logic [63:0] exp_u);
      check("idle_in_ready_s", 128'(in_ready_s), 128'(1));
      check("idle_in_ready_u", 128'(in_ready_u), 128'(1));
      a = av; b = bv; is_signed = s; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("busy_calc", 128'(busy_s), 128'(1));
      for (int e = 1; e <= 5; e++) begin
         if (poke && e == 1) begin
            a = $urandom; b = $urandom; is_signed = ~s; in_valid = 1'b1;
         end
         @(posedge clk); #1;
         if (e == 4) check("out_valid_early", 128'(out_valid_s), 128'(0));
      end
      check("out_valid_edge5_s", 128'(out_valid_s), 128'(1));
      check("out_valid_edge5_u", 128'(out_valid_u), 128'(1));
      check("p_s", 128'(p_s), 128'(exp_s));
      check("p_u", 128'(p_u), 128'(exp_u));
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check("hold_p", 128'(p_s), 128'(exp_s));
         check("hold_in_ready", 128'(in_ready_s), 128'(0));
         check("hold_out_valid", 128'(out_valid_s), 128'(1));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("handshake_out_valid", 128'(out_valid_s), 128'(0));
      check("handshake_in_ready", 128'(in_ready_s), 128'(1));
      check("handshake_p_kept", 128'(p_s), 128'(exp_s));
   endtask

   task automatic run64(input logic [63:0] av, input logic [63:0] bv, input bit s);
      logic [127:0] exp;
      exp = model64(av, bv, s);
      check("idle_in_ready_64", 128'(in_ready64), 128'(1));
      a64 = av; b64 = bv; is_signed64 = s; in_valid64 = 1'b1; out_ready64 = 1'b0;
      @(posedge clk); #1;
      in_valid64 = 1'b0;
      for (int e = 1; e <= 17; e++) begin
         @(posedge clk); #1;
         if (e == 16) check("out_valid_early_64", 128'(out_valid64), 128'(0));
      end
      check("out_valid_edge17_64", 128'(out_valid64), 128'(1));
      check("p_64", p64, exp);
      out_ready64 = 1'b1;
      @(posedge clk); #1;
      out_ready64 = 1'b0;
      check("handshake_64", 128'(out_valid64), 128'(0));
   endtask

   initial begin
      logic [31:0] av, bv;
      bit          s;

      rst = 1'b1;
      in_valid = 1'b0; is_signed = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      in_valid64 = 1'b0; is_signed64 = 1'b0; out_ready64 = 1'b0; a64 = '0; b64 = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 128'(in_ready_s), 128'(1));
      check("rst_out_valid", 128'(out_valid_s), 128'(0));
      check("rst_busy", 128'(busy_s), 128'(0));
      check("rst_p", 128'(p_s), 128'(0));
      check("rst_p_64", p64, 128'(0));
      rst = 1'b0;
      @(posedge clk); #1;

      run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1'b0,
            64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFE_0000_0001);
      run32(32'h8000_0000, 32'h0000_0001, 1'b1, 0, 1'b0,
            64'hFFFF_FFFF_8000_0000, 64'h0000_0000_8000_0000);
      run32(32'h8000_0000, 32'h8000_0000, 1'b1, 0, 1'b0,
            64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000);
      run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 1'b0,
            64'h0000_0000_0000_0001, 64'hFFFF_FFFE_0000_0001);
      run32(32'h0000_0000, 32'hFFFF_FFFB, 1'b1, 0, 1'b0,
            64'h0, 64'h0);
      run32(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 10, 1'b1,
            model32(32'h1234_5678, 32'h9ABC_DEF0, 1'b1),
            model32(32'h1234_5678, 32'h9ABC_DEF0, 1'b0));

      // Reset held across the second CALC edge discards the transaction.
      a = 32'h0001_0003; b = 32'h0002_0007; is_signed = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midcalc_rst_in_ready", 128'(in_ready_s), 128'(1));
      check("midcalc_rst_busy", 128'(busy_s), 128'(0));
      check("midcalc_rst_p", 128'(p_s), 128'(0));
      for (int n = 0; n < 6; n++) begin
         @(posedge clk); #1;
         check("post_rst_no_valid", 128'(out_valid_s), 128'(0));
      end
      run32(32'd3, 32'd5, 1'b0, 0, 1'b0, 64'd15, 64'd15);

      for (int n = 0; n < 16; n++) begin
         av = pick32();
         bv = pick32();
         s  = 1'($urandom_range(0, 1));
         run32(av, bv, s, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
               model32(av, bv, s), model32(av, bv, 1'b0));
      end

      run64(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
      run64(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1);
      run64(64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0007, 1'b1);
      for (int n = 0; n < 5; n++) begin
         run64({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
